mul_share_arbiter: RTL and testbench

Round-robin scheduler that shares one registered 32x32 signed multiplier (fixed latency `LAT`) among `NREQ` requesters. It accepts at most one operand pair per cycle through a valid/ready handshake, drives the multiplier operand inputs, and tracks each issued operation's requester ID through a tag pipeline. When the product returns, the block routes it back as a one-cycle response to that requester. It sits between the multiplier datapath and client blocks such as filter taps or MAC engines.

---
 rtl/mul_share_arbiter.sv | 104 ++++++++++
 tb/tb_mul_share_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mul_share_arbiter.sv
// Round-robin front end sharing one external pipelined 32x32 signed multiplier among NREQ
// requesters; a tag pipeline carries each requester ID alongside its operation.
module mul_share_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned LAT  = 2,
    parameter int unsigned IDW  = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              en,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*32-1:0] req_a,
    input  logic [NREQ*32-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic [31:0]       mul_x,
    output logic [31:0]       mul_y,
    input  logic [63:0]       mul_z,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [63:0]       rsp_data,
    output logic              busy
);

    logic [IDW-1:0]         ptr_q, ptr_d;
    logic [NREQ-1:0]        grant;
    logic [IDW-1:0]         grant_id;
    logic                   found;
    logic [31:0]            mul_x_q, mul_x_d;
    logic [31:0]            mul_y_q, mul_y_d;
    // Stage 0 travels with mul_x/mul_y; stages 1..LAT shadow the multiplier pipeline.
    logic [LAT:0]           tag_vld_q, tag_vld_d;
    logic [LAT:0][IDW-1:0]  tag_id_q, tag_id_d;
    logic [NREQ-1:0]        rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]         rsp_id_q, rsp_id_d;
    logic [63:0]            rsp_data_q, rsp_data_d;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        for (int k = 0; k < int'(NREQ); k++) begin
            logic [IDW-1:0] idx;
            idx = IDW'((int'(ptr_q) + k) % int'(NREQ));
            if (!found && en && !RESET && req_valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = idx;
            end
        end
    end

    always_comb begin
        ptr_d   = ptr_q;
        mul_x_d = '0;
        mul_y_d = '0;
        if (found) begin
            ptr_d   = IDW'((int'(grant_id) + 1) % int'(NREQ));
            mul_x_d = req_a[32*int'(grant_id) +: 32];
            mul_y_d = req_b[32*int'(grant_id) +: 32];
        end
        tag_vld_d = {tag_vld_q[LAT-1:0], found};
        tag_id_d  = {tag_id_q[LAT-1:0], grant_id};

        rsp_valid_d = '0;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        if (tag_vld_q[LAT]) begin
            rsp_valid_d = NREQ'(1) << tag_id_q[LAT];
            rsp_id_d    = tag_id_q[LAT];
            rsp_data_d  = mul_z;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ptr_q       <= '0;
            mul_x_q     <= '0;
            mul_y_q     <= '0;
            tag_vld_q   <= '0;
            tag_id_q    <= '0;
            rsp_valid_q <= '0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            mul_x_q     <= mul_x_d;
            mul_y_q     <= mul_y_d;
            tag_vld_q   <= tag_vld_d;
            tag_id_q    <= tag_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign req_ready = grant;
    assign mul_x     = mul_x_q;
    assign mul_y     = mul_y_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (|tag_vld_q) || (|rsp_valid_q);

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter: stimulus pushes expected responses into a queue,
// a negedge monitor pops and checks them, and a behavioural multiplier closes the loop.
module tb_mul_share_arbiter;

    localparam int NREQ = 4;
    localparam int LAT  = 2;
    localparam int IDW  = 2;

    logic              CLK = 1'b0;
    logic              RESET;
    logic              en;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*32-1:0] req_a, req_b;
    logic [NREQ-1:0]   req_ready;
    logic [31:0]       mul_x, mul_y;
    logic [63:0]       mul_z;
    logic [NREQ-1:0]   rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [63:0]       rsp_data;
    logic              busy;

    typedef struct {
        logic [IDW-1:0] id;
        logic [63:0]    data;
        int             cyc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    logic [63:0] pipe [LAT];

    mul_share_arbiter #(.NREQ(NREQ), .LAT(LAT), .IDW(IDW)) dut (
        .CLK(CLK), .RESET(RESET), .en(en), .req_valid(req_valid), .req_a(req_a),
        .req_b(req_b), .req_ready(req_ready), .mul_x(mul_x), .mul_y(mul_y), .mul_z(mul_z),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    // External multiplier: LAT register stages after mul_x/mul_y.
    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= $signed({{32{mul_x[31]}}, mul_x}) * $signed({{32{mul_y[31]}}, mul_y});
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign mul_z = pipe[LAT-1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge CLK) begin
        if (rsp_valid !== '0) begin
            if (q.size() == 0) begin
                check("unexpected_rsp_valid", 64'(rsp_valid), 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("rsp_valid", 64'(rsp_valid), 64'(4'b0001 << e.id));
                check("rsp_id", 64'(rsp_id), 64'(e.id));
                check("rsp_data", rsp_data, e.data);
                check("rsp_latency", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // One cycle of stimulus: operands packed {a3,a2,a1,a0}; grant checked before the edge.
    task automatic step(input logic e, input logic [3:0] v, input logic [127:0] a,
                        input logic [127:0] b, input logic [3:0] exp_g,
                        input logic [63:0] exp_d, input logic push);
        exp_t ent;
        @(negedge CLK);
        en = e; req_valid = v; req_a = a; req_b = b;
        #1;
        check("req_ready", 64'(req_ready), 64'(exp_g));
        if (push && exp_g != 4'd0) begin
            ent.id = '0;
            for (int i = 0; i < NREQ; i++) if (exp_g[i]) ent.id = IDW'(i);
            ent.data = exp_d;
            ent.cyc  = cyc + 1 + LAT + 1;
            q.push_back(ent);
        end
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge CLK);
            #2;
            if (q.size() == 0) done = 1'b1;
        end
        if (!done) check("drain_timeout", 64'(q.size()), 64'd0);
        else begin
            check("busy_on_last_rsp", 64'(busy), 64'd1);
            @(negedge CLK);
            #2;
            check("busy_after_last_rsp", 64'(busy), 64'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        RESET = 1'b1; en = 1'b1; req_valid = 4'b1111; req_a = '1; req_b = '1;
        repeat (2) @(negedge CLK);
        #1;
        check("reset_req_ready", 64'(req_ready), 64'd0);
        check("reset_mul_x", 64'(mul_x), 64'd0);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_rsp_data", rsp_data, 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        req_valid = '0;
        @(negedge CLK);
        RESET = 1'b0;

        // Contention: all valid, grants rotate 0,1,2,3.
        for (int i = 0; i < 4; i++) begin
            logic [63:0] pr [4];
            pr[0] = 64'sd377; pr[1] = 64'sd4455; pr[2] = -64'sd600; pr[3] = 64'sd0;
            step(1'b1, 4'b1111,
                 {32'sd0, -32'sd100, -32'sd81, 32'sd13},
                 {-32'sd300, 32'sd6, -32'sd55, 32'sd29},
                 4'b0001 << i, pr[i], 1'b1);
        end
        step(1'b1, 4'b0000, '0, '0, 4'b0000, 64'd0, 1'b0);
        check("busy_in_flight", 64'(busy), 64'd1);
        drain();

        // Fairness: requesters 0 and 2 alternate.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 4'b0101, {32'd0, 32'sd5, 32'd0, 32'sd2}, {32'd0, 32'sd7, 32'd0, 32'sd3},
                 (i % 2 == 0) ? 4'b0001 : 4'b0100, (i % 2 == 0) ? 64'sd6 : 64'sd35, 1'b1);
        end
        step(1'b1, 4'b0000, '0, '0, 4'b0000, 64'd0, 1'b0);
        drain();

        // Single request from requester 1 (ptr is 3, search 3,0,1).
        step(1'b1, 4'b0010, {32'd0, 32'd0, 32'sd15, 32'd0}, {32'd0, 32'd0, -32'sd31, 32'd0},
             4'b0010, -64'sd465, 1'b1);
        step(1'b1, 4'b0000, '0, '0, 4'b0000, 64'd0, 1'b0);
        drain();

        // Enable gating, then first grant at ptr=2.
        for (int i = 0; i < 3; i++)
            step(1'b0, 4'b1111, '1, '1, 4'b0000, 64'd0, 1'b0);
        step(1'b1, 4'b1111, {32'd1, 32'sd7, 32'd1, 32'd1}, {32'd1, -32'sd9, 32'd1, 32'd1},
             4'b0100, -64'sd63, 1'b1);

        // Extremes back to back, then enable drops with both in flight.
        step(1'b1, 4'b0001, {96'd0, 32'h8000_0000}, {96'd0, 32'h8000_0000},
             4'b0001, 64'h4000_0000_0000_0000, 1'b1);
        step(1'b1, 4'b0010, {64'd0, 32'h8000_0000, 32'd0}, {64'd0, 32'h7FFF_FFFF, 32'd0},
             4'b0010, 64'hC000_0000_8000_0000, 1'b1);
        step(1'b0, 4'b1111, '0, '0, 4'b0000, 64'd0, 1'b0);
        drain();

        // Reset mid-flight: requester 3 issues, reset one cycle later discards it.
        step(1'b1, 4'b1000, {-32'sd12340, 96'd0}, {-32'sd54321, 96'd0}, 4'b1000, 64'd0, 1'b0);
        @(negedge CLK);
        req_valid = '0;
        check("pre_reset_busy", 64'(busy), 64'd1);
        RESET = 1'b1;
        #1;
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("midreset_mul_y", 64'(mul_y), 64'd0);
        check("midreset_rsp_id", 64'(rsp_id), 64'd0);
        check("midreset_rsp_data", rsp_data, 64'd0);
        @(negedge CLK);
        RESET = 1'b0;
        repeat (8) @(negedge CLK);
        check("final_queue_empty", 64'(q.size()), 64'd0);
        check("final_busy", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
